// File: rtl/ifchain_match_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined priority/unique match chain.
package ifchain_pkg;

  typedef enum logic [1:0] {
    MODE_PRIORITY = 2'd0,
    MODE_UNIQUE0  = 2'd1,
    MODE_UNIQUE   = 2'd2
  } mode_e;

  // Number of pipeline segments needed to cover all entries.
  function automatic int calc_stages(input int entries, input int seg);
    return (entries + seg - 1) / seg;
  endfunction

  // Index width; never narrower than one bit.
  function automatic int calc_iw(input int entries);
    return (entries <= 1) ? 1 : $clog2(entries);
  endfunction

  // Packed width of the per-stage carry {value, hit, idx, multi}.
  // Modules declare the matching packed struct locally with their own WIDTH/IW.
  function automatic int carry_width(input int width, input int iw);
    return width + iw + 2;
  endfunction

endpackage

// File: rtl/ifchain_match_pipe_if.sv
// Table-write, lookup-request and result signals of the match pipe.
interface ifchain_match_pipe_if #(
  parameter int WIDTH = 32,
  parameter int IW    = 4
);
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             wr_enable;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [IW-1:0]    out_idx;
  logic             out_multi;
  logic             out_none_err;

  modport master (
    output wr_en, wr_idx, wr_data, wr_enable, in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_hit, out_idx, out_multi, out_none_err
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, wr_enable, in_valid, in_value, out_ready,
    output in_ready, out_valid, out_hit, out_idx, out_multi, out_none_err
  );
endinterface

// File: rtl/ifchain_match_pipe_seg.sv
// One pipeline segment: compares the carried value against COUNT consecutive
// entries starting at BASE and merges the result into the incoming carry.
// A hit already present in the carry came from a lower index, so it keeps priority.
module ifchain_seg
  import ifchain_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IW    = 4,
  parameter int BASE  = 0,
  parameter int COUNT = 1,
  localparam int CW   = carry_width(WIDTH, IW)
) (
  input  logic [WIDTH-1:0] seg_data [COUNT],
  input  logic [COUNT-1:0] seg_en,
  input  logic [CW-1:0]    carry_in,
  output logic [CW-1:0]    carry_out
);

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             hit;
    logic [IW-1:0]    idx;
    logic             multi;
  } carry_t;

  carry_t           cin;
  carry_t           cmerge;
  logic [COUNT-1:0] match;

  assign cin = carry_t'(carry_in);

  for (genvar j = 0; j < COUNT; j++) begin : g_cmp
    assign match[j] = seg_en[j] && (seg_data[j] == cin.value);
  end

  // Lowest-index-first merge; any further hit marks the lookup as multi-hit.
  always_comb begin
    cmerge = cin;
    for (int j = 0; j < COUNT; j++) begin
      if (match[j]) begin
        if (cmerge.hit) begin
          cmerge.multi = 1'b1;
        end else begin
          cmerge.hit = 1'b1;
          cmerge.idx = IW'(BASE + j);
        end
      end
    end
  end

  assign carry_out = cmerge;

endmodule

// File: rtl/ifchain_match_pipe.sv
// Programmable compare table searched lowest-index-first, split into
// pipeline segments of at most SEG compares. One input register, then one
// register per segment; a single global stall freezes every stage together.
module ifchain_match_pipe
  import ifchain_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 12,
  parameter int SEG     = 10,
  parameter int MODE    = 0,
  localparam int STAGES = calc_stages(ENTRIES, SEG),
  localparam int IW     = calc_iw(ENTRIES),
  localparam int CW     = carry_width(WIDTH, IW)
) (
  input logic                clk,
  input logic                rst_n,
  ifchain_match_pipe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             hit;
    logic [IW-1:0]    idx;
    logic             multi;
  } carry_t;

  localparam mode_e MODE_E = mode_e'(MODE);

  logic [WIDTH-1:0]   tbl_data [ENTRIES];
  logic [ENTRIES-1:0] tbl_en;
  logic [CW-1:0]      pipe_q [STAGES+1];
  logic [STAGES:0]    vld_q;
  logic [CW-1:0]      seg_out [STAGES];
  carry_t             head_c;
  carry_t             tail_c;
  logic               adv;
  logic               unused_tail;

  assign adv          = !vld_q[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;

  // Table writes land at the edge regardless of the stall; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) tbl_data[i] <= '0;
      tbl_en <= '0;
    end else if (bus.wr_en && (32'(bus.wr_idx) < ENTRIES)) begin
      tbl_data[bus.wr_idx] <= bus.wr_data;
      tbl_en[bus.wr_idx]   <= bus.wr_enable;
    end
  end

  // Fresh lookup enters with no hit recorded.
  always_comb begin
    head_c       = '0;
    head_c.value = bus.in_value;
  end

  // Whole pipe advances together; holding everything on stall keeps bubbles in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s <= STAGES; s++) pipe_q[s] <= '0;
    end else if (adv) begin
      vld_q     <= {vld_q[STAGES-1:0], bus.in_valid};
      pipe_q[0] <= head_c;
      for (int s = 0; s < STAGES; s++) pipe_q[s+1] <= seg_out[s];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_seg
    localparam int BASE  = s * SEG;
    localparam int COUNT = ((s + 1) * SEG > ENTRIES) ? (ENTRIES - BASE) : SEG;

    logic [WIDTH-1:0] seg_data [COUNT];

    for (genvar j = 0; j < COUNT; j++) begin : g_slice
      assign seg_data[j] = tbl_data[BASE+j];
    end

    ifchain_seg #(
      .WIDTH (WIDTH),
      .IW    (IW),
      .BASE  (BASE),
      .COUNT (COUNT)
    ) u_seg (
      .seg_data  (seg_data),
      .seg_en    (tbl_en[BASE +: COUNT]),
      .carry_in  (pipe_q[s]),
      .carry_out (seg_out[s])
    );
  end

  assign tail_c           = carry_t'(pipe_q[STAGES]);
  assign unused_tail      = ^tail_c.value;
  assign bus.out_valid    = vld_q[STAGES];
  assign bus.out_hit      = tail_c.hit;
  assign bus.out_idx      = tail_c.idx;
  assign bus.out_multi    = (MODE_E != MODE_PRIORITY) && tail_c.multi;
  assign bus.out_none_err = (MODE_E == MODE_UNIQUE) && vld_q[STAGES] && !tail_c.hit;

endmodule

// File: tb/tb_ifchain_match_pipe.sv
// Bench for ifchain_match_pipe: three instances (priority, unique0, unique)
// share one stimulus stream and are checked against a table-scan model.
module tb_ifchain_match_pipe;
  import ifchain_pkg::*;

  localparam int WIDTH   = 32;
  localparam int ENTRIES = 12;
  localparam int SEG     = 10;
  localparam int IW      = 4;
  localparam int NDUT    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             wr_en = 1'b0;
  logic [IW-1:0]    wr_idx = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_enable = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic             out_ready = 1'b1;

  logic          o_ready [NDUT];
  logic          o_valid [NDUT];
  logic          o_hit   [NDUT];
  logic [IW-1:0] o_idx   [NDUT];
  logic          o_multi [NDUT];
  logic          o_none  [NDUT];

  ifchain_match_pipe_if #(.WIDTH(WIDTH), .IW(IW)) bus [NDUT] ();

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    assign bus[k].wr_en     = wr_en;
    assign bus[k].wr_idx    = wr_idx;
    assign bus[k].wr_data   = wr_data;
    assign bus[k].wr_enable = wr_enable;
    assign bus[k].in_valid  = in_valid;
    assign bus[k].in_value  = in_value;
    assign bus[k].out_ready = out_ready;
    assign o_ready[k] = bus[k].in_ready;
    assign o_valid[k] = bus[k].out_valid;
    assign o_hit[k]   = bus[k].out_hit;
    assign o_idx[k]   = bus[k].out_idx;
    assign o_multi[k] = bus[k].out_multi;
    assign o_none[k]  = bus[k].out_none_err;

    ifchain_match_pipe #(
      .WIDTH(WIDTH), .ENTRIES(ENTRIES), .SEG(SEG), .MODE(k)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[k])
    );
  end

  int errors = 0;
  int checks = 0;

  // Reference model: the table as the bench believes it to be.
  logic [WIDTH-1:0] m_data [ENTRIES];
  logic             m_en   [ENTRIES];

  typedef struct {
    int cnt;
    int idx;
  } exp_t;

  exp_t sbq [$];
  bit   sb_on = 0;
  bit   acc = 0;
  int   pops = 0;

  typedef struct {
    int          cfg;
    logic [31:0] value;
    int          cnt;
    int          idx;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s mode=%0d got=%0d expected=%0d", name, k, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] v);
    exp_t e;
    e.cnt = 0;
    e.idx = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_en[i] && m_data[i] == v) begin
        if (e.cnt == 0) e.idx = i;
        e.cnt++;
      end
    end
    return e;
  endfunction

  task automatic compare_result(input exp_t e, input string tag);
    for (int k = 0; k < NDUT; k++) begin
      chk({tag, "_hit"},   k, 32'(o_hit[k]),   32'(e.cnt > 0));
      chk({tag, "_idx"},   k, 32'(o_idx[k]),   32'(e.idx));
      chk({tag, "_multi"}, k, 32'(o_multi[k]), 32'(k != 0 && e.cnt > 1));
      chk({tag, "_none"},  k, 32'(o_none[k]),  32'(k == 2 && e.cnt == 0));
    end
  endtask

  // One clock: sample and check on the falling edge, return just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++)
      chk("in_ready_rule", k, 32'(o_ready[k]), 32'(!(o_valid[k] && !out_ready)));
    acc = in_valid && o_ready[0];
    if (sb_on) begin
      if (o_valid[0] && out_ready) begin
        chk("sb_queue_nonempty", 0, 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          compare_result(e, "sb");
          pops++;
        end
      end
      if (acc) sbq.push_back(model(in_value));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input logic [WIDTH-1:0] data, input logic en);
    wr_en = 1'b1;
    wr_idx = IW'(idx);
    wr_data = data;
    wr_enable = en;
    if (idx < ENTRIES) begin
      m_data[idx] = data;
      m_en[idx] = en;
    end
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic load_table_a();
    for (int i = 0; i < ENTRIES; i++) write_entry(i, WIDTH'(i + 1), 1'b1);
  endtask

  task automatic load_table_b();
    write_entry(3, 7, 1'b1);
    write_entry(6, 100, 1'b1);
    write_entry(10, 7, 1'b1);
    write_entry(5, 6, 1'b0);
    write_entry(15, 50, 1'b1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!o_valid[0] && lat < 20) begin
      cycle();
      lat++;
    end
    chk("out_valid_arrives", 0, 32'(o_valid[0]), 32'd1);
  endtask

  task automatic run_lookup(input string tag, input logic [31:0] v, input int cnt, input int idx, input bit chk_lat);
    int   lat;
    exp_t e;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_value = v;
    cycle();
    chk({tag, "_accept"}, 0, 32'(acc), 32'd1);
    in_valid = 1'b0;
    wait_out(lat);
    if (chk_lat) chk({tag, "_latency"}, 0, 32'(lat), 32'd2);
    e.cnt = cnt;
    e.idx = idx;
    compare_result(e, tag);
    cycle();
  endtask

  initial begin
    int   lat;
    int   sent;
    int   guard;
    int   pops0;
    int   stale;
    exp_t e;
    bit   pat [4];

    vecs[0]  = '{0, 32'd11,  1, 10};
    vecs[1]  = '{0, 32'd19,  0, 0};
    vecs[2]  = '{0, 32'd1,   1, 0};
    vecs[3]  = '{0, 32'd10,  1, 9};
    vecs[4]  = '{0, 32'd12,  1, 11};
    vecs[5]  = '{0, 32'd0,   0, 0};
    vecs[6]  = '{1, 32'd7,   2, 3};
    vecs[7]  = '{1, 32'd4,   0, 0};
    vecs[8]  = '{1, 32'd6,   0, 0};
    vecs[9]  = '{1, 32'd5,   1, 4};
    vecs[10] = '{1, 32'd50,  0, 0};
    vecs[11] = '{1, 32'd100, 1, 6};
    vecs[12] = '{1, 32'd11,  0, 0};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    for (int i = 0; i < ENTRIES; i++) begin
      m_data[i] = '0;
      m_en[i] = 1'b0;
    end

    #12;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_out_valid", k, 32'(o_valid[k]), 32'd0);
      chk("rst_out_hit",   k, 32'(o_hit[k]),   32'd0);
      chk("rst_out_idx",   k, 32'(o_idx[k]),   32'd0);
      chk("rst_out_multi", k, 32'(o_multi[k]), 32'd0);
      chk("rst_out_none",  k, 32'(o_none[k]),  32'd0);
      chk("rst_in_ready",  k, 32'(o_ready[k]), 32'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven directed lookups over two table configurations.
    load_table_a();
    for (int i = 0; i < 13; i++) begin
      if (i == 6) load_table_b();
      run_lookup($sformatf("vec%0d", i), vecs[i].value, vecs[i].cnt, vecs[i].idx, 1'b1);
    end

    // Write landing while a lookup is between segments.
    load_table_a();
    in_valid = 1'b1;
    in_value = 12;
    cycle();
    in_valid = 1'b0;
    write_entry(11, 99, 1'b1);
    wait_out(lat);
    e.cnt = 0; e.idx = 0;
    compare_result(e, "late_wr_seg1");
    cycle();
    in_valid = 1'b1;
    in_value = 1;
    cycle();
    in_valid = 1'b0;
    write_entry(0, 77, 1'b1);
    wait_out(lat);
    e.cnt = 1; e.idx = 0;
    compare_result(e, "late_wr_seg0");
    cycle();
    run_lookup("new_entry0", 77, 1, 0, 1'b1);

    // Backpressure: stream 1..12 with out_ready pattern 1,0,0,1.
    load_table_a();
    sb_on = 1;
    pops0 = pops;
    sent = 0;
    guard = 0;
    while ((sent < 12 || sbq.size() != 0 || o_valid[0]) && guard < 200) begin
      in_valid = (sent < 12);
      in_value = WIDTH'(sent + 1);
      out_ready = pat[guard % 4];
      cycle();
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 0, 32'(sent), 32'd12);
    chk("bp_results", 0, 32'(pops - pops0), 32'd12);

    // Randomized traffic against the model; table fixed while lookups fly.
    sb_on = 0;
    for (int i = 0; i < ENTRIES; i++)
      write_entry(i, WIDTH'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    sb_on = 1;
    pops0 = pops;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 1) != 0);
      in_value = WIDTH'($urandom_range(0, 9));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) cycle();
    chk("rand_drain_empty", 0, 32'(sbq.size()), 32'd0);
    chk("rand_some_results", 0, 32'(pops - pops0 > 50), 32'd1);
    sb_on = 0;

    // Reset with two lookups in flight and the first one stalled at the output.
    load_table_a();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_value = 3;
    cycle();
    in_value = 5;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_valid", 0, 32'(o_valid[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("midrst_out_valid", k, 32'(o_valid[k]), 32'd0);
      chk("midrst_out_none",  k, 32'(o_none[k]),  32'd0);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      m_data[i] = '0;
      m_en[i] = 1'b0;
    end
    sbq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int n = 0; n < 6; n++) begin
      cycle();
      if (o_valid[0] || o_valid[1] || o_valid[2]) stale++;
    end
    chk("no_stale_after_rst", 0, 32'(stale), 32'd0);
    run_lookup("post_rst_v1", 1, 0, 0, 1'b1);
    run_lookup("post_rst_v0", 0, 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifchain_match_pipe.md
Name: ifchain_match_pipe

Overview:
- Parametrised successor to the flat if/else-if value chain: a programmable table of ENTRIES compare values, searched in lowest-index-first priority order.
- The search is split into pipeline segments of at most SEG comparisons each, so no single stage builds an if-chain deeper than SEG.
- Each result carries checks for unique0 (multiple hits) and unique (no hit) violations.
- Sits in the lint/regression infrastructure as the synthesizable reference model for priority, unique0 and unique chains.

Parameters:
- WIDTH, 32: compare value width.
- ENTRIES, 12: table entries; must be ≥1.
- SEG, 10: maximum comparisons per pipeline stage; must be ≥1.
- MODE, 0: chain mode. 0 = priority (no checks), 1 = unique0 (flag multi-hit), 2 = unique (flag multi-hit and no-hit).
- Derived (localparam): STAGES = ceil(ENTRIES/SEG); IW = max(1, clog2(ENTRIES)).

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- wr_en in 1: table write strobe.
- wr_idx in IW: entry to write.
- wr_data in WIDTH: compare value.
- wr_enable in 1: entry-valid bit written with wr_data.
- in_valid in 1: lookup request.
- in_ready out 1: lookup accepted when in_valid && in_ready.
- in_value in WIDTH: value to match.
- out_valid out 1: result valid.
- out_ready in 1: result consumed.
- out_hit out 1: at least one enabled entry matched.
- out_idx out IW: lowest matching index (0 when no hit).
- out_multi out 1: more than one entry matched; driven 0 when MODE=0.
- out_none_err out 1: MODE=2 and no hit; otherwise 0.

Behaviour:
- Reset (async assert, sync-release use): all entry-valid bits 0, table data 0, every pipeline valid 0, out_valid/out_hit/out_idx/out_multi/out_none_err all 0.
- Global stall: adv = !out_valid || out_ready; in_ready = adv. Every stage register loads only when adv=1. When adv=0 all stages hold, so no bubble collapse.
- Stage s compares the carried value against entries s*SEG .. min((s+1)*SEG, ENTRIES)-1. It carries value, hit, idx and multi forward.
  - First hit sets hit and idx.
  - A later hit while hit is already set sets multi.
  - Earlier stages win priority.
- Latency: accept at edge N → out_valid at edge N+STAGES, provided no stall. Throughput: 1 lookup per cycle.
- Only enabled entries compare. Disabled entries never hit, even if their data equals the value.
- Writes take effect at the clock edge, independent of the stall. A stage evaluating in the same cycle sees the old table contents. In-flight lookups whose segment has not yet been evaluated see the new contents.
- wr_idx ≥ ENTRIES: write ignored.
- ENTRIES not a multiple of SEG: the last stage is partial, with no phantom entries.
- ENTRIES ≤ SEG: STAGES=1, latency 1.
- Reset mid-operation: all in-flight lookups are dropped immediately and no result is produced afterward. The table is cleared.
- Outputs are registered; there is no combinational path from in_* to out_*. in_ready depends combinationally only on out_valid and out_ready.

Decomposition:
- Package ifchain_pkg holds:
  - mode enum: MODE_PRIORITY=0, MODE_UNIQUE0=1, MODE_UNIQUE=2;
  - per-stage carry struct {value, hit, idx, multi} as a parameterised-width typedef helper;
  - STAGES and IW functions.
- One sub-module, ifchain_seg: combinational segment compare with the priority-merge of the incoming carry. It is instantiated STAGES times by generate. Registers stay in the top level.

Test Plan:
- Base lookup: ENTRIES=12, SEG=10, MODE=0; entries i hold value i+1, all enabled. Lookup 11 → out_idx=10, out_hit=1, out_valid exactly 2 cycles after accept. Lookup 19 → out_hit=0, out_idx=0, out_none_err=0.
- Unique0 duplicates: MODE=1; entries 3 and 10 both hold 7. Lookup 7 → out_idx=3, out_multi=1. Lookup 4 → out_multi=0.
- Unique no-hit: MODE=2; lookup 19 → out_none_err=1, out_hit=0. Disable entry 5 (value 6) and lookup 6 → out_hit=0, out_none_err=1.
- Backpressure: stream 1..12 back-to-back with out_ready toggled 1,0,0,1,…
  - Results emerge in order with idx 0..11.
  - No loss or duplication.
  - in_ready=0 exactly while out_valid && !out_ready.
- Write during flight: accept lookup 12, then next cycle rewrite entry 11 to 99 before stage 1 evaluates. The result is out_hit=0. Entry-0 rewrites after acceptance do not affect the result.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 lookups in flight.
  - out_valid drops immediately.
  - After release, no stale result appears.
  - A lookup of any value gives out_hit=0 because the table is cleared.
